board_ctl: RTL and testbench

Game-control stage upstream of the per-square highlight/draw stages in the tic-tac-toe video pipeline.
- Converts mouse position and left-button clicks into three outputs:
  - a one-hot hover vector, whose bit n−1 drives the `squareN` input of the matching draw stage;
  - the X/O occupancy of the 3×3 board;
  - turn, win and draw status.
- Runs a game-flow FSM gated by `start_en`, detects win and draw, and holds the result until the game is stopped.

---
 rtl/board_ctl.sv | 177 +++++++++++++++++
 tb/tb_board_ctl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctl.sv
`default_nettype none
// ============================================================================
// Module   : board_ctl
// Brief    : Tic-tac-toe game control: hover decode, click-driven moves,
//            win/draw detection. Define BOARD_CTL_SYNC_EN to synchronise
//            mouse_left through two flops before edge detection.
// Revision : 1.0 - initial release
// ============================================================================
module board_ctl #(
    parameter int H_EDGE1 = 341,
    parameter int H_EDGE2 = 685,
    parameter int V_EDGE1 = 256,
    parameter int V_EDGE2 = 515,
    parameter int H_MAX   = 1023,
    parameter int V_MAX   = 767
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        start_en,
    output logic [8:0]  square_hl,
    output logic [8:0]  cell_x,
    output logic [8:0]  cell_o,
    output logic        turn_o,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam logic [11:0] c_h_edge1 = 12'(H_EDGE1);
    localparam logic [11:0] c_h_edge2 = 12'(H_EDGE2);
    localparam logic [11:0] c_v_edge1 = 12'(V_EDGE1);
    localparam logic [11:0] c_v_edge2 = 12'(V_EDGE2);
    localparam logic [11:0] c_h_max   = 12'(H_MAX);
    localparam logic [11:0] c_v_max   = 12'(V_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [8:0] r_cell_x, r_cell_o, w_cell_x_nxt, w_cell_o_nxt;
    logic [8:0] r_square_hl, w_square_hl_nxt;
    logic       r_turn, w_turn_nxt, r_over, w_over_nxt;
    logic [1:0] r_winner, w_winner_nxt;
    logic [1:0] w_col, w_row;
    logic       w_col_ok, w_row_ok, w_valid;
    logic [3:0] w_idx;
    logic [8:0] w_onehot, w_mover;
    logic       w_btn, r_btn_prev, w_click, w_cell_free;

    function automatic logic f_has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Column/row default to 0 when out of range so idx never exceeds 8.
    always_comb begin
        w_col    = 2'd0;
        w_col_ok = 1'b1;
        if (mouse_xpos < c_h_edge1)       w_col = 2'd0;
        else if (mouse_xpos < c_h_edge2)  w_col = 2'd1;
        else if (mouse_xpos <= c_h_max)   w_col = 2'd2;
        else                              w_col_ok = 1'b0;

        w_row    = 2'd0;
        w_row_ok = 1'b1;
        if (mouse_ypos < c_v_edge1)       w_row = 2'd0;
        else if (mouse_ypos < c_v_edge2)  w_row = 2'd1;
        else if (mouse_ypos <= c_v_max)   w_row = 2'd2;
        else                              w_row_ok = 1'b0;
    end

    assign w_valid     = w_col_ok & w_row_ok;
    assign w_idx       = 4'(w_row) * 4'd3 + 4'(w_col);
    assign w_onehot    = w_valid ? (9'd1 << w_idx) : 9'd0;
    assign w_cell_free = w_valid && ((w_onehot & (r_cell_x | r_cell_o)) == 9'd0);

`ifdef BOARD_CTL_SYNC_EN
    logic r_sync1, r_sync2;
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= mouse_left;
            r_sync2 <= r_sync1;
        end
    end
    assign w_btn = r_sync2;
`else
    assign w_btn = mouse_left;
`endif

    assign w_click = w_btn & ~r_btn_prev;
    assign w_mover = r_turn ? r_cell_o : r_cell_x;

    always_comb begin
        w_state_nxt     = r_state;
        w_cell_x_nxt    = r_cell_x;
        w_cell_o_nxt    = r_cell_o;
        w_turn_nxt      = r_turn;
        w_over_nxt      = r_over;
        w_winner_nxt    = r_winner;
        w_square_hl_nxt = (r_state == S_PLAY) ? w_onehot : 9'd0;
        if (!start_en) begin
            w_state_nxt  = S_IDLE;
            w_cell_x_nxt = 9'd0;
            w_cell_o_nxt = 9'd0;
            w_turn_nxt   = 1'b0;
            w_over_nxt   = 1'b0;
            w_winner_nxt = 2'b00;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_PLAY;
                S_PLAY: begin
                    if (w_click && w_cell_free) begin
                        if (r_turn) w_cell_o_nxt = r_cell_o | w_onehot;
                        else        w_cell_x_nxt = r_cell_x | w_onehot;
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (f_has_line(w_mover)) begin
                        w_state_nxt  = S_OVER;
                        w_over_nxt   = 1'b1;
                        w_winner_nxt = r_turn ? 2'b10 : 2'b01;
                    end else if (&(r_cell_x | r_cell_o)) begin
                        w_state_nxt  = S_OVER;
                        w_over_nxt   = 1'b1;
                        w_winner_nxt = 2'b11;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_turn_nxt  = ~r_turn;
                    end
                end
                default: w_state_nxt = S_OVER;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cell_x    <= 9'd0;
            r_cell_o    <= 9'd0;
            r_turn      <= 1'b0;
            r_over      <= 1'b0;
            r_winner    <= 2'b00;
            r_square_hl <= 9'd0;
            r_btn_prev  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cell_x    <= w_cell_x_nxt;
            r_cell_o    <= w_cell_o_nxt;
            r_turn      <= w_turn_nxt;
            r_over      <= w_over_nxt;
            r_winner    <= w_winner_nxt;
            r_square_hl <= w_square_hl_nxt;
            r_btn_prev  <= w_btn;
        end
    end

    assign square_hl = r_square_hl;
    assign cell_x    = r_cell_x;
    assign cell_o    = r_cell_o;
    assign turn_o    = r_turn;
    assign game_over = r_over;
    assign winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_board_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_ctl
// Brief    : Self-checking bench for board_ctl using a move scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_ctl;

`ifdef BOARD_CTL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] mouse_xpos = 12'd0;
    logic [11:0] mouse_ypos = 12'd0;
    logic        mouse_left = 1'b0;
    logic        start_en = 1'b0;
    logic [8:0]  square_hl, cell_x, cell_o;
    logic        turn_o, game_over;
    logic [1:0]  winner;

    board_ctl dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .start_en   (start_en),
        .square_hl  (square_hl),
        .cell_x     (cell_x),
        .cell_o     (cell_o),
        .turn_o     (turn_o),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string      tag;
        logic [8:0] x;
        logic [8:0] o;
        logic       t;
        logic       ov;
        logic [1:0] w;
    } exp_t;
    exp_t sb[$];

    // Reference game model
    logic [8:0] m_x, m_o;
    logic       m_t, m_ov;
    logic [1:0] m_w;
    int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                 '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int         xs [3] = '{100, 500, 800};
    int         ys [3] = '{100, 400, 600};

    function automatic logic m_line(input logic [8:0] b);
        for (int i = 0; i < 8; i++)
            if (b[lines[i][0]] && b[lines[i][1]] && b[lines[i][2]]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_x = 9'd0; m_o = 9'd0; m_t = 1'b0; m_ov = 1'b0; m_w = 2'b00;
    endtask

    task automatic model_click(input int idx);
        if (!m_ov && !m_x[idx] && !m_o[idx]) begin
            if (m_t) m_o[idx] = 1'b1; else m_x[idx] = 1'b1;
            if (m_line(m_t ? m_o : m_x)) begin
                m_ov = 1'b1; m_w = m_t ? 2'b10 : 2'b01;
            end else if ((m_x | m_o) == 9'h1FF) begin
                m_ov = 1'b1; m_w = 2'b11;
            end else begin
                m_t = ~m_t;
            end
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "/cell_x"}, cell_x, e.x);
        chk({e.tag, "/cell_o"}, cell_o, e.o);
        chk({e.tag, "/turn"}, turn_o, e.t);
        chk({e.tag, "/over"}, game_over, e.ov);
        chk({e.tag, "/winner"}, winner, e.w);
    endtask

    task automatic click_cell(input string tag, input int idx);
        exp_t e;
        @(negedge pclk);
        mouse_xpos = 12'(xs[idx % 3]);
        mouse_ypos = 12'(ys[idx / 3]);
        mouse_left = 1'b1;
        model_click(idx);
        e.tag = tag; e.x = m_x; e.o = m_o; e.t = m_t; e.ov = m_ov; e.w = m_w;
        sb.push_back(e);
        repeat (LAT + 3) @(negedge pclk);
        mouse_left = 1'b0;
        repeat (LAT + 2) @(negedge pclk);
        sb_check();
    endtask

    task automatic restart();
        @(negedge pclk);
        start_en = 1'b0;
        @(negedge pclk);
        start_en = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        model_reset();
    endtask

    task automatic hover(input string tag, input int x, input int y, input logic [8:0] exp);
        @(negedge pclk);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        @(posedge pclk);
        #1 chk(tag, square_hl, exp);
    endtask

    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        model_reset();
        #2;
        chk("rst_cell_x", cell_x, 9'd0);
        chk("rst_hl", square_hl, 9'd0);
        chk("rst_status", {game_over, turn_o, winner}, 4'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        mouse_xpos = 12'd800; mouse_ypos = 12'd600;
        repeat (2) @(negedge pclk);
        chk("idle_hl", square_hl, 9'd0);
        start_en = 1'b1;
        repeat (2) @(negedge pclk);

        hover("hover_800_600", 800, 600, 9'h100);
        hover("hover_1030_600", 1030, 600, 9'h000);
        hover("hover_340_255", 340, 255, 9'h001);
        hover("hover_341_256", 341, 256, 9'h010);
        hover("hover_1023_767", 1023, 767, 9'h100);
        hover("hover_500_768", 500, 768, 9'h000);

        // First move with exact latency checks
        @(negedge pclk);
        mouse_xpos = 12'd100; mouse_ypos = 12'd100;
        mouse_left = 1'b1;
        model_click(0);
        repeat (LAT + 1) @(posedge pclk);
        #1;
        chk("lat_cell_x", cell_x, 9'h001);
        chk("lat_turn_early", turn_o, 1'b0);
        @(posedge pclk);
        #1 chk("lat_turn", turn_o, 1'b1);
        @(negedge pclk);
        mouse_left = 1'b0;
        repeat (LAT + 2) @(negedge pclk);
        click_cell("o_occupied", 0);
        click_cell("o_move", 1);
        chk("o_cell_o", cell_o, 9'h002);

        // Asynchronous reset mid-game
        @(negedge pclk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cells", {cell_x, cell_o}, 18'd0);
        chk("arst_status", {game_over, turn_o, winner}, 4'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        model_reset();
        mouse_xpos = 12'd500; mouse_ypos = 12'd400;
        repeat (3) @(negedge pclk);
        chk("arst_play_hl", square_hl, 9'h010);
        chk("arst_turn", turn_o, 1'b0);

        // Win for X on the top row
        restart();
        click_cell("win_x1", 0);
        click_cell("win_o4", 3);
        click_cell("win_x2", 1);
        click_cell("win_o5", 4);
        click_cell("win_x3", 2);
        chk("win_cell_x", cell_x, 9'h007);
        chk("win_status", {game_over, winner}, 3'b101);
        click_cell("win_frozen", 8);

        // Draw
        restart();
        for (int i = 0; i < 9; i++) click_cell($sformatf("draw_%0d", i), draw_seq[i]);
        chk("draw_full", cell_x | cell_o, 9'h1FF);
        chk("draw_status", {game_over, winner}, 3'b111);

        // Abort: start_en drops together with a valid click
        restart();
        @(negedge pclk);
        mouse_xpos = 12'd800; mouse_ypos = 12'd100;
        mouse_left = 1'b1;
        start_en   = 1'b0;
        @(posedge pclk);
        #1;
        chk("abort_cells", {cell_x, cell_o}, 18'd0);
        chk("abort_turn", turn_o, 1'b0);
        @(posedge pclk);
        #1 chk("abort_idle_hl", square_hl, 9'd0);
        @(negedge pclk);
        start_en = 1'b1;
        repeat (LAT + 6) @(negedge pclk);
        chk("held_no_move", cell_x, 9'd0);
        chk("held_hl", square_hl, 9'h004);
        mouse_left = 1'b0;
        repeat (LAT + 2) @(negedge pclk);
        model_reset();
        click_cell("repress", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
